switch_bank_io: RTL and testbench
=================================

SWITCH_BANK_IO -- requirements
Module: switch_bank_io

Interface
REQ-001 Parameter SW_W, default 16, switch count; legal range 8..32.
REQ-002 Parameter N_BTN, default 4, push-button count; legal range 1..16.
REQ-003 Parameter DB_CYCLES, default 20000, debounce stability window in clk cycles; minimum 2.
REQ-004 Port clk  input  1  system clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-low.
REQ-006 Port io_rd  input  1  MMIO read strobe, one cycle per access.
REQ-007 Port address  input  32  MMIO byte address, sampled when io_rd=1.
REQ-008 Port sw_raw  input  SW_W  asynchronous switch levels.
REQ-009 Port btn_raw  input  N_BTN  asynchronous button levels, active-high.
REQ-010 Port rd_data  output  32  read data.
REQ-011 Port rd_valid  output  1  rd_data qualifier, one-cycle pulse.
REQ-012 Port btn_pending  output  1  OR of all sticky button flags.

Function
REQ-013 Every sw_raw and btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each synchronized bit SHALL feed a debouncer; the debounced level changes only after DB_CYCLES consecutive cycles of the new value; any mismatch restarts the count.
REQ-015 Debounce latency SHALL be exactly 2 (sync) + DB_CYCLES cycles from a clean raw edge to the debounced output change.
REQ-016 A 0->1 transition of debounced button i SHALL set sticky flag i on the following cycle; 1->0 transitions have no effect on flags.
REQ-017 Reads SHALL have 1-cycle latency: io_rd in cycle N gives rd_valid=1 and rd_data in cycle N+1; otherwise rd_valid=0, rd_data=0.
REQ-018 Address map, zero-extended to 32 bits unless stated; SWD = debounced switches:
  - 0xFFFF_FF00: sticky button flags, read-to-clear.
  - 0xFFFF_FF04: debounced button levels, no side effect.
  - 0xFFFF_FFF1: SWD.
  - 0xFFFF_FFF3: SWD[SW_W-1:SW_W-8].
  - 0xFFFF_FFF5: SWD[SW_W-1:SW_W-8], sign-extended.
  - 0xFFFF_FFF7: SWD[2:0].
  - 0xFFFF_FFF9: SWD[7:0], sign-extended.
  - any other address: rd_data=0, rd_valid=1, no side effect.
REQ-019 A read of 0xFFFF_FF00 SHALL return the flag values present in cycle N and clear them at the end of cycle N.
REQ-020 If a new rising edge on button i coincides with its read-clear, flag i SHALL remain set after the cycle; the read returns the pre-edge value.
REQ-021 btn_pending SHALL be a registered OR of the flags, updated in the same cycle as the flags.
REQ-022 Back-to-back io_rd on consecutive cycles SHALL each produce one rd_valid pulse, in order.

Reset
REQ-023 On rst=0 at a clk edge: synchronizers, debounced levels and debounce counters to 0; flags to 0; rd_data=0, rd_valid=0, btn_pending=0.
REQ-024 A read in flight when reset asserts SHALL be dropped: no rd_valid in the following cycle.
REQ-025 After reset release, inputs held high SHALL appear as debounced 1 after 2+DB_CYCLES cycles and SHALL set their button flags.

Structure
REQ-026 Shared package switch_io_pkg SHALL hold the seven address constants and the default parameter values.
REQ-027 Sub-module debouncer (1-bit, parameter DB_CYCLES, counter width clog2(DB_CYCLES+1)) SHALL be instantiated SW_W+N_BTN times via generate.

Verification (DB_CYCLES=4, SW_W=16, N_BTN=4)
REQ-028 sw_raw=0x8A5C held for 10 cycles, then read FFF1/F3/F5/F7/F9 -> 0x00008A5C, 0x0000008A, 0xFFFFFF8A, 0x00000004, 0x0000005C.
REQ-029 sw_raw bit0 toggles every 3 cycles for 30 cycles -> debounced bit0 never changes; FFF1 read returns 0.
REQ-030 btn_raw=0x2 held 8 cycles -> btn_pending=1; read FF00 -> 0x00000002; second read -> 0x00000000, btn_pending=0.
REQ-031 Button 0 rising edge timed to coincide with the FF00 read-clear cycle -> read returns 0; next read returns 0x00000001.
REQ-032 io_rd to 0xFFFF_FF00 with rst=0 in the next cycle -> no rd_valid; flags cleared; read of 0x1234_5678 -> rd_valid=1, rd_data=0.

Source files
------------

// File: rtl/switch_bank_io_pkg.sv
// Shared constants for the switch/button MMIO block: default parameter
// values, the read address map and a small address decoder.
package switch_io_pkg;

    localparam int SW_W_DEFAULT      = 16;
    localparam int N_BTN_DEFAULT     = 4;
    localparam int DB_CYCLES_DEFAULT = 20000;

    localparam logic [31:0] ADDR_BTN_FLAGS = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_BTN_LEVEL = 32'hFFFF_FF04;
    localparam logic [31:0] ADDR_SW_ALL    = 32'hFFFF_FFF1;
    localparam logic [31:0] ADDR_SW_HI     = 32'hFFFF_FFF3;
    localparam logic [31:0] ADDR_SW_HI_SX  = 32'hFFFF_FFF5;
    localparam logic [31:0] ADDR_SW_LO3    = 32'hFFFF_FFF7;
    localparam logic [31:0] ADDR_SW_LO8_SX = 32'hFFFF_FFF9;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_BTN_FLAGS,
        SEL_BTN_LEVEL,
        SEL_SW_ALL,
        SEL_SW_HI,
        SEL_SW_HI_SX,
        SEL_SW_LO3,
        SEL_SW_LO8_SX
    } rd_sel_e;

    // Map a byte address onto the register it selects; unmapped reads give SEL_NONE.
    function automatic rd_sel_e decode_addr(input logic [31:0] addr);
        case (addr)
            ADDR_BTN_FLAGS: return SEL_BTN_FLAGS;
            ADDR_BTN_LEVEL: return SEL_BTN_LEVEL;
            ADDR_SW_ALL:    return SEL_SW_ALL;
            ADDR_SW_HI:     return SEL_SW_HI;
            ADDR_SW_HI_SX:  return SEL_SW_HI_SX;
            ADDR_SW_LO3:    return SEL_SW_LO3;
            ADDR_SW_LO8_SX: return SEL_SW_LO8_SX;
            default:        return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/switch_bank_io_debouncer.sv
// Single-bit debouncer: the output follows the input only after the input
// has differed from it for DB_CYCLES consecutive cycles.
module debouncer
    import switch_io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int                 CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Count cycles of disagreement; any agreement restarts the window.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt  <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/switch_bank_io.sv
// Memory-mapped switch and push-button bank: synchronizes and debounces
// every input, keeps sticky rising-edge flags for the buttons and serves
// single-cycle-latency reads.
module switch_bank_io
    import switch_io_pkg::*;
#(
    parameter int SW_W      = SW_W_DEFAULT,
    parameter int N_BTN     = N_BTN_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             io_rd,
    input  logic [31:0]      address,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             btn_pending
);

    localparam int N_IN = SW_W + N_BTN;

    logic [N_IN-1:0]  sync1, sync2, db;
    logic [SW_W-1:0]  sw_db;
    logic [N_BTN-1:0] btn_db, btn_prev, btn_rise;
    logic [N_BTN-1:0] flags, flags_next;
    logic [31:0]      rd_word, rd_data_q;
    logic             rd_valid_q, rd_clear;
    rd_sel_e          sel;

    // Two-flop synchronizer for all raw inputs, buttons above switches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_raw, sw_raw};
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_db
        debouncer #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .din  (sync2[i]),
            .dout (db[i])
        );
    end

    assign sw_db    = db[SW_W-1:0];
    assign btn_db   = db[N_IN-1:SW_W];
    assign btn_rise = btn_db & ~btn_prev;

    assign sel      = decode_addr(address);
    assign rd_clear = io_rd && (sel == SEL_BTN_FLAGS);

    // A rising edge in the clearing cycle wins over the clear.
    assign flags_next = (rd_clear ? '0 : flags) | btn_rise;

    // Select the read word for the decoded address.
    // NOTE: rd_word gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_word = '0;
        case (sel)
            SEL_BTN_FLAGS: rd_word = 32'(flags);
            SEL_BTN_LEVEL: rd_word = 32'(btn_db);
            SEL_SW_ALL:    rd_word = 32'(sw_db);
            SEL_SW_HI:     rd_word = {24'd0, sw_db[SW_W-1:SW_W-8]};
            SEL_SW_HI_SX:  rd_word = {{24{sw_db[SW_W-1]}}, sw_db[SW_W-1:SW_W-8]};
            SEL_SW_LO3:    rd_word = {29'd0, sw_db[2:0]};
            SEL_SW_LO8_SX: rd_word = {{24{sw_db[7]}}, sw_db[7:0]};
            default:       rd_word = '0;
        endcase
    end

    // Sticky button flags, edge-detect history and their registered OR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flags       <= '0;
            btn_prev    <= '0;
            btn_pending <= 1'b0;
        end else begin
            flags       <= flags_next;
            btn_prev    <= btn_db;
            btn_pending <= |flags_next;
        end
    end

    // Read response register, one cycle behind the strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= io_rd;
            rd_data_q  <= io_rd ? rd_word : '0;
        end
    end

    // A response due in the same cycle reset asserts is suppressed at once,
    // so an in-flight read never surfaces.
    assign rd_valid = rd_valid_q & rst;
    assign rd_data  = rst ? rd_data_q : '0;

endmodule

// File: tb/tb_switch_bank_io.sv
// Directed bench for switch_bank_io with a read scoreboard: expected read
// data is queued when a read is issued and compared when rd_valid appears.
module tb_switch_bank_io;
    import switch_io_pkg::*;

    localparam int SW_W      = 16;
    localparam int N_BTN     = 4;
    localparam int DB_CYCLES = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             io_rd = 1'b0;
    logic [31:0]      address = '0;
    logic [SW_W-1:0]  sw_raw = '0;
    logic [N_BTN-1:0] btn_raw = '0;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             btn_pending;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    switch_bank_io #(
        .SW_W      (SW_W),
        .N_BTN     (N_BTN),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io_rd       (io_rd),
        .address     (address),
        .sw_raw      (sw_raw),
        .btn_raw     (btn_raw),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .btn_pending (btn_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle read and queue its expected data.
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        io_rd   = 1'b1;
        address = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick(1);
        io_rd   = 1'b0;
        address = '0;
    endtask

    // Let outstanding responses arrive, then require the queue to be empty.
    task automatic drained(input string tag);
        @(negedge clk);
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
        tick(1);
    endtask

    task automatic chk_pend(input string tag, input logic e);
        @(negedge clk);
        check(tag, {31'd0, btn_pending}, {31'd0, e});
        tick(1);
    endtask

    // Scoreboard: pop and compare on every response; idle data must be zero.
    always @(negedge clk) begin
        if (rd_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", {31'd0, rd_valid}, 32'd0);
            end else begin
                check(tag_q.pop_front(), rd_data, exp_q.pop_front());
            end
        end else begin
            check("idle_rd_data", rd_data, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_btn_pending", {31'd0, btn_pending}, 32'd0);
        tick(1);
        rst = 1'b1;
        rd("rst_flags",  ADDR_BTN_FLAGS, 32'h0);
        rd("rst_levels", ADDR_BTN_LEVEL, 32'h0);
        rd("rst_sw",     ADDR_SW_ALL,    32'h0);
        drained("drain_reset");

        // Switch views, pattern with negative high byte
        sw_raw = 16'h8A5C;
        tick(10);
        rd("sw_all_8a5c",    ADDR_SW_ALL,    32'h0000_8A5C);
        rd("sw_hi_8a5c",     ADDR_SW_HI,     32'h0000_008A);
        rd("sw_hi_sx_8a5c",  ADDR_SW_HI_SX,  32'hFFFF_FF8A);
        rd("sw_lo3_8a5c",    ADDR_SW_LO3,    32'h0000_0004);
        rd("sw_lo8_sx_8a5c", ADDR_SW_LO8_SX, 32'h0000_005C);
        rd("unmapped_fff0",  32'hFFFF_FFF0,  32'h0);
        rd("unmapped_ff08",  32'hFFFF_FF08,  32'h0);
        drained("drain_8a5c");

        // Switch views, pattern with negative low byte
        sw_raw = 16'h41C3;
        tick(10);
        rd("sw_all_41c3",    ADDR_SW_ALL,    32'h0000_41C3);
        rd("sw_hi_sx_41c3",  ADDR_SW_HI_SX,  32'h0000_0041);
        rd("sw_lo3_41c3",    ADDR_SW_LO3,    32'h0000_0003);
        rd("sw_lo8_sx_41c3", ADDR_SW_LO8_SX, 32'hFFFF_FFC3);
        drained("drain_41c3");

        // Bouncing bit0 never settles; reads run back to back
        sw_raw = '0;
        tick(10);
        for (int c = 0; c < 30; c++) begin
            sw_raw[0] = ((c / 3) % 2 == 0);
            rd("bounce_sw", ADDR_SW_ALL, 32'h0);
        end
        sw_raw = '0;
        tick(8);
        rd("bounce_final", ADDR_SW_ALL, 32'h0);
        drained("drain_bounce");

        // Button 1 press, level read, read-to-clear
        btn_raw = 4'h2;
        tick(8);
        chk_pend("btn1_pending_set", 1'b1);
        rd("btn1_level",  ADDR_BTN_LEVEL, 32'h2);
        rd("btn1_flags",  ADDR_BTN_FLAGS, 32'h2);
        rd("btn1_flags2", ADDR_BTN_FLAGS, 32'h0);
        chk_pend("btn1_pending_clr", 1'b0);
        btn_raw = 4'h0;
        tick(10);
        chk_pend("btn_release_no_flag", 1'b0);
        rd("btn_release_flags", ADDR_BTN_FLAGS, 32'h0);
        drained("drain_btn1");

        // Button 0 edge lands in the clearing cycle
        btn_raw = 4'h1;
        tick(2 + DB_CYCLES);
        rd("coincide_read", ADDR_BTN_FLAGS, 32'h0);
        chk_pend("coincide_pending", 1'b1);
        rd("coincide_next", ADDR_BTN_FLAGS, 32'h1);
        drained("drain_coincide");

        // Read in flight when reset asserts is dropped
        btn_raw = 4'h9;
        tick(8);
        chk_pend("btn3_pending_set", 1'b1);
        io_rd   = 1'b1;
        address = ADDR_BTN_FLAGS;
        tick(1);
        io_rd   = 1'b0;
        address = '0;
        rst     = 1'b0;
        @(negedge clk);
        check("rst_drop_rd_valid", {31'd0, rd_valid}, 32'd0);
        tick(2);
        rst = 1'b1;
        chk_pend("post_rst_pending", 1'b0);
        rd("post_rst_flags",    ADDR_BTN_FLAGS, 32'h0);
        rd("post_rst_unmapped", 32'h1234_5678,  32'h0);
        drained("drain_post_rst");

        // Held buttons re-debounce after reset and set their flags
        tick(8);
        chk_pend("held_pending", 1'b1);
        rd("held_levels", ADDR_BTN_LEVEL, 32'h9);
        rd("held_flags",  ADDR_BTN_FLAGS, 32'h9);
        drained("drain_held");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
